// File: rtl/fps_counter_if.sv
// Frame-pulse / frame-rate bundle shared by the fps_counter and whatever drives it.
// Latency: none (plain wires).
// Backpressure: none; new_frame_in is a level-sampled pulse and fps_out is free-running.
// Ports: new_frame_in (1 bit, frame completion pulse), fps_out (WIDTH bits, averaged frame rate).
interface fps_counter_if #(
  parameter int WIDTH = 32
);
  logic             new_frame_in;
  logic [WIDTH-1:0] fps_out;

  // master: render pipeline side, produces frame pulses and reads the rate
  modport master (output new_frame_in, input fps_out);
  // slave: the fps_counter itself
  modport slave  (input new_frame_in, output fps_out);
endinterface

// File: rtl/fps_counter.sv
// Counts frame pulses over a WAIT_SECONDS window and divides by WAIT_SECONDS with a restoring divider.
// Latency: fps_out updates exactly WIDTH+1 cycles after each window-end cycle; holds between updates.
// Backpressure: none; new_frame_in is sampled every cycle, fps_out may be read at any time.
// Ports: clk_in (clock), rst_in (sync active-high reset), bus.new_frame_in (frame pulse), bus.fps_out (rate).
// Option: define FPS_COUNTER_ROUND_EN to round to nearest (halves up) instead of truncating.
module fps_counter #(
  parameter int WIDTH             = 32,
  parameter int ONE_SECOND_CYCLES = 1000,
  parameter int WAIT_SECONDS      = 10
) (
  input  logic         clk_in,
  input  logic         rst_in,
  fps_counter_if.slave bus
);

  localparam int N  = ONE_SECOND_CYCLES * WAIT_SECONDS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    LAST_CYC = CW'(N - 1);
  localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
  localparam logic [WIDTH:0]   DIVISOR  = (WIDTH + 1)'(WAIT_SECONDS);
  localparam logic [WIDTH-1:0] MAX_VAL  = '1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cyc_cnt;
  logic [WIDTH-1:0] r_frame_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_fps;

  logic             w_win_end;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_snap;
  logic [WIDTH-1:0] w_dividend;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_win_end = (r_cyc_cnt == LAST_CYC);

  // A pulse on the closing cycle still belongs to the closing window.
  assign w_sum  = {1'b0, r_frame_cnt} + (WIDTH + 1)'(bus.new_frame_in);
  assign w_snap = w_sum[WIDTH] ? MAX_VAL : w_sum[WIDTH-1:0];

`ifdef FPS_COUNTER_ROUND_EN
  // Adding half the divisor turns truncation into round-half-up.
  logic [WIDTH:0] w_rsum;
  assign w_rsum     = {1'b0, w_snap} + (WIDTH + 1)'(WAIT_SECONDS / 2);
  assign w_dividend = w_rsum[WIDTH] ? MAX_VAL : w_rsum[WIDTH-1:0];
`else
  assign w_dividend = w_snap;
`endif

  // One restoring step: the dividend shifts out of r_quo MSB-first while
  // quotient bits shift in at the bottom. The remainder stays below the
  // divisor, so the true difference always fits in WIDTH bits.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_trial >= DIVISOR);
  assign w_diff    = w_trial[WIDTH-1:0] - DIVISOR[WIDTH-1:0];
  assign w_rem_nxt = w_ge ? w_diff : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  // Window timing and frame accumulation.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cyc_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_cyc_cnt <= w_win_end ? '0 : r_cyc_cnt + 1'b1;
      if (w_win_end) begin
        r_frame_cnt <= '0;
      end else if (bus.new_frame_in && (r_frame_cnt != MAX_VAL)) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Divider FSM. fps_out is loaded on the edge that completes the last
  // iteration so it appears WIDTH+1 cycles after the window end; the
  // following DONE cycle only returns the FSM to IDLE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_bit_cnt <= '0;
      r_fps     <= '0;
    end else if (w_win_end) begin
      r_state   <= S_DIV;
      r_rem     <= '0;
      r_quo     <= w_dividend;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        S_DIV: begin
          r_rem     <= w_rem_nxt;
          r_quo     <= w_quo_nxt;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            r_fps   <= w_quo_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fps_out = r_fps;

endmodule

// File: tb/tb_fps_counter.sv
// Directed bench for fps_counter: back-to-back windows driven from a vector table.
// Latency: each window's result is expected at local cycle 32 of the next window.
// Backpressure: none.
module tb_fps_counter;

  localparam int WIDTH = 32;
  localparam int OSC   = 1000;
  localparam int WS    = 10;
  localparam int N     = OSC * WS;
  localparam int NV    = 6;

`ifdef FPS_COUNTER_ROUND_EN
  localparam int          BND     = 15;
  localparam logic [31:0] E_FIRST5 = 32'd1;
  localparam logic [31:0] E_BND    = 32'd2;
`else
  localparam int          BND     = 10;
  localparam logic [31:0] E_FIRST5 = 32'd0;
  localparam logic [31:0] E_BND    = 32'd1;
`endif

  logic clk_in = 1'b0;
  logic rst_in;

  fps_counter_if #(.WIDTH(WIDTH)) bus ();

  fps_counter #(
    .WIDTH            (WIDTH),
    .ONE_SECOND_CYCLES(OSC),
    .WAIT_SECONDS     (WS)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // kind: 0 idle, 1 always high, 2 every arg-th cycle, 3 first arg cycles,
  // 4 first arg-1 cycles plus the last cycle of the window
  typedef struct {
    int          kind;
    int          arg;
    logic [31:0] exp_fps;
    string       name;
  } vec_t;

  vec_t vecs[NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic pat(input int kind, input int arg, input int c);
    case (kind)
      1:       return 1'b1;
      2:       return (c % arg) == 0;
      3:       return c < arg;
      4:       return (c < arg - 1) || (c == N - 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: fps_out=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Runs ncyc cycles from local cycle 0 of a window. fps_out must equal
  // old_v throughout, except that with has_upd it must switch to new_v at
  // local cycle 32 and keep it.
  task automatic run_cycles(input int kind, input int arg, input int ncyc,
                            input logic [31:0] old_v, input logic [31:0] new_v,
                            input bit has_upd, input string tag);
    int          hold_bad;
    int          first_bad;
    logic [31:0] first_act;
    logic [31:0] first_exp;
    logic [31:0] e;
    hold_bad  = 0;
    first_bad = -1;
    first_act = '0;
    first_exp = '0;
    for (int c = 0; c < ncyc; c++) begin
      e = (has_upd && c >= 32) ? new_v : old_v;
      if (has_upd && c == 32) begin
        check({tag, "_update"}, bus.fps_out, new_v);
      end else if (bus.fps_out !== e) begin
        hold_bad++;
        if (first_bad < 0) begin
          first_bad = c;
          first_act = bus.fps_out;
          first_exp = e;
        end
      end
      bus.new_frame_in = pat(kind, arg, c);
      @(posedge clk_in);
      #1;
    end
    n_cmp++;
    if (hold_bad != 0) begin
      n_bad++;
      $display("FAIL %s_hold: %0d bad cycles, first at local cycle %0d fps_out=%0d expected=%0d",
               tag, hold_bad, first_bad, first_act, first_exp);
    end
  endtask

  initial begin
    logic [31:0] old_v;
    logic [31:0] new_v;

    vecs[0] = '{2, 10,  32'd100,  "every10"};
    vecs[1] = '{3, 5,   E_FIRST5, "first5"};
    vecs[2] = '{3, 4,   32'd0,    "first4"};
    vecs[3] = '{4, BND, E_BND,    "last_cycle"};
    vecs[4] = '{3, BND, E_BND,    "first_cycle"};
    vecs[5] = '{1, 0,   32'd1000, "all_high"};

    rst_in           = 1'b1;
    bus.new_frame_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check("reset_state", bus.fps_out, 32'd0);

    // Windows run back to back; window w shows result w-1 from local cycle 32.
    for (int w = 0; w < NV; w++) begin
      old_v = (w >= 2) ? vecs[w-2].exp_fps : 32'd0;
      new_v = (w >= 1) ? vecs[w-1].exp_fps : 32'd0;
      run_cycles(vecs[w].kind, vecs[w].arg, N, old_v, new_v, (w >= 1), vecs[w].name);
    end

    // Division of the all-high window is in flight; reset it at local cycle 10
    // with a frame pulse present to confirm reset wins.
    run_cycles(0, 0, 10, vecs[NV-2].exp_fps, vecs[NV-1].exp_fps, 1'b1, "pre_reset");
    check("pre_reset_value", bus.fps_out, vecs[NV-2].exp_fps);
    rst_in           = 1'b1;
    bus.new_frame_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in           = 1'b0;
    bus.new_frame_in = 1'b0;
    check("reset_mid_division", bus.fps_out, 32'd0);

    // No stale 1000 may appear, and the window timing restarts from cycle 0.
    run_cycles(2, 10, N, 32'd0, 32'd0, 1'b0, "post_reset_w0");
    run_cycles(0, 0, 40, 32'd0, 32'd100, 1'b1, "post_reset_w1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
